// File: rtl/car_pkg.sv
// Shared car definitions used by the manual-drive controller, the 7-seg display
// stage and the other mode controllers.
//  - 4-bit car state codes (the shared state encoding seen on the display)
//  - drive_sw_t: the manual-drive switch bundle after synchronisation
//  - is_powered / is_rolling: state-class helpers
package car_pkg;

    localparam logic [3:0] OFF      = 4'b0000;
    localparam logic [3:0] NO_ST    = 4'b0011;
    localparam logic [3:0] START    = 4'b0111;
    localparam logic [3:0] MOVEF    = 4'b0110;
    localparam logic [3:0] MOVEB    = 4'b0101;
    localparam logic [3:0] WAIT_CMD = 4'b1000;
    localparam logic [3:0] LEFT_T   = 4'b1001;
    localparam logic [3:0] RIGHT_T  = 4'b1010;
    localparam logic [3:0] CIRCLE_T = 4'b1011;
    localparam logic [3:0] KEEP_GO  = 4'b1110;
    localparam logic [3:0] SEMI_F   = 4'b1111;

    typedef struct packed {
        logic throttle;
        logic clutch;
        logic brake;
        logic reverse;
        logic left_sw;
        logic right_sw;
    } drive_sw_t;

    // Any state in which the car is switched on in manual mode.
    function automatic logic is_powered(input logic [3:0] st);
        return (st == NO_ST) || (st == START) || (st == MOVEF) || (st == MOVEB);
    endfunction

    // States in which the turn indicators are allowed to light.
    function automatic logic is_rolling(input logic [3:0] st);
        return (st == START) || (st == MOVEF) || (st == MOVEB);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a stability filter.
// The filtered output only takes the synchronised value after that value has
// differed from the current output for DEBOUNCE_CYC consecutive cycles; any
// return to the old level restarts the count.
// Ports:
//  clk    in  1  system clock
//  rst_n  in  1  asynchronous active-low reset
//  btn_i  in  1  raw button, asynchronous to clk
//  btn_o  out 1  debounced button level
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic btn_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds how many consecutive cycles the synchronised input has
    // disagreed with the filtered output. It is zero whenever they agree, so a
    // bounce back to the old level restarts the measurement.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_o = db_q;

endmodule

// File: rtl/manual_drive_fsm.sv
// Manual-driving controller of the simulated car. Conditions the power button,
// detects a long press for power-on and tracks throttle/clutch/brake/reverse to
// produce the shared car state code plus drive and indicator commands.
// Ports:
//  clk         in  1  system clock, 100 MHz
//  rst_n       in  1  asynchronous active-low reset
//  power_btn   in  1  raw power button, active-high, asynchronous
//  throttle    in  1  level switch
//  clutch      in  1  level switch
//  brake       in  1  level switch
//  reverse     in  1  1 = reverse gear
//  left_sw     in  1  turn-left switch
//  right_sw    in  1  turn-right switch
//  state       out 4  car state code (car_pkg encoding); also the FSM state itself
//  move_fwd    out 1  1 only in MOVEF
//  move_bwd    out 1  1 only in MOVEB
//  turn_left   out 1  left indicator, only in START/MOVEF/MOVEB
//  turn_right  out 1  right indicator, only in START/MOVEF/MOVEB
module manual_drive_fsm
    import car_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYC = 100_000_000,
    parameter int unsigned CNT_W          = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_btn,
    input  logic       throttle,
    input  logic       clutch,
    input  logic       brake,
    input  logic       reverse,
    input  logic       left_sw,
    input  logic       right_sw,
    output logic [3:0] state,
    output logic       move_fwd,
    output logic       move_bwd,
    output logic       turn_left,
    output logic       turn_right
);

    localparam logic [CNT_W-1:0] PRESS_MAX  = CNT_W'(LONG_PRESS_CYC);
    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(LONG_PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] PRESS_ONE  = CNT_W'(1);

    drive_sw_t        sw_meta_q;
    drive_sw_t        sw_q;
    logic             btn_db;
    logic             db_prev_q;
    logic [CNT_W-1:0] press_cnt_q;
    logic [CNT_W-1:0] press_cnt_d;
    logic             long_seen_q;
    logic             long_seen_d;
    logic             long_evt;
    logic             rel_evt;
    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic             move_fwd_q;
    logic             move_bwd_q;
    logic             turn_left_q;
    logic             turn_right_q;
    logic             wrong_gear;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_power_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_i (power_btn),
        .btn_o (btn_db)
    );

    // ---------------------------------------------------------------
    // Press tracking on the debounced button
    // ---------------------------------------------------------------
    // long_evt fires on the cycle the counter steps from LONG_PRESS_CYC-1 to
    // LONG_PRESS_CYC; saturation stops it firing twice in one press.
    assign long_evt = btn_db && (press_cnt_q == PRESS_LAST);

    // long_seen_q remembers that this press already produced a long event, so
    // its release is not treated as an off request. It is still set during the
    // release cycle and clears one cycle later.
    assign rel_evt  = db_prev_q && !btn_db && !long_seen_q;

    always_comb begin
        press_cnt_d = '0;
        if (btn_db) begin
            press_cnt_d = (press_cnt_q == PRESS_MAX) ? PRESS_MAX : press_cnt_q + PRESS_ONE;
        end
        long_seen_d = btn_db && (long_seen_q || long_evt);
    end

    // ---------------------------------------------------------------
    // Car state machine (priority order matters: power-off first)
    // ---------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wrong_gear = 1'b0;
        case (state_q)
            OFF: begin
                if (long_evt) state_d = NO_ST;
            end
            NO_ST: begin
                if (rel_evt)                          state_d = OFF;
                else if (sw_q.throttle && sw_q.clutch)  state_d = START;
                else if (sw_q.throttle)               state_d = OFF;  // stall
            end
            START: begin
                if (rel_evt) begin
                    state_d = OFF;
                end else if (sw_q.throttle && !sw_q.clutch && !sw_q.brake) begin
                    state_d = sw_q.reverse ? MOVEB : MOVEF;
                end
            end
            MOVEF, MOVEB: begin
                // Gear lever moved against the direction of travel.
                wrong_gear = (state_q == MOVEF) ? sw_q.reverse : !sw_q.reverse;
                if (rel_evt)                               state_d = OFF;
                else if (wrong_gear && !sw_q.clutch)       state_d = OFF;
                else if (sw_q.brake)                       state_d = NO_ST;
                else if (sw_q.clutch || !sw_q.throttle)    state_d = START;
            end
            default: state_d = OFF;  // illegal or foreign code
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q    <= '0;
            sw_q         <= '0;
            db_prev_q    <= 1'b0;
            press_cnt_q  <= '0;
            long_seen_q  <= 1'b0;
            state_q      <= OFF;
            move_fwd_q   <= 1'b0;
            move_bwd_q   <= 1'b0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
        end else begin
            sw_meta_q    <= {throttle, clutch, brake, reverse, left_sw, right_sw};
            sw_q         <= sw_meta_q;
            db_prev_q    <= btn_db;
            press_cnt_q  <= press_cnt_d;
            long_seen_q  <= long_seen_d;
            // All outputs come from state_d so they switch together with state.
            state_q      <= state_d;
            move_fwd_q   <= (state_d == MOVEF);
            move_bwd_q   <= (state_d == MOVEB);
            turn_left_q  <= sw_q.left_sw && is_rolling(state_d);
            turn_right_q <= sw_q.right_sw && is_rolling(state_d);
        end
    end

    assign state      = state_q;
    assign move_fwd   = move_fwd_q;
    assign move_bwd   = move_bwd_q;
    assign turn_left  = turn_left_q;
    assign turn_right = turn_right_q;

endmodule
